rom_uart_loader: RTL
====================

# rom_uart_loader

Boot loader that sits upstream of the instruction ROM on `mother_board`. It takes the byte stream from the UART receiver, frames and checks it, and writes 32-bit instruction words into `rom` at consecutive addresses. The CPU is held in reset until a complete, checksum-valid image has been written. This replaces direct `rom.mem` preloading on hardware, and lets bench programs be delivered over `uart_rx`.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: ROM word-address width. Maximum image size is 2^ADDR_WIDTH words.
- `TIMEOUT`, default 100000: idle cycles allowed between bytes inside a frame before the frame is aborted.

Ports:
- `clk` input, 1: system clock. The block uses this single clock only.
- `reset` input, 1: asynchronous, active-high reset.
- `rx_valid` input, 1: one-cycle strobe from the UART receiver; a received byte is present.
- `rx_data` input, 8: received byte, qualified by `rx_valid`.
- `rom_we` output, 1: one-cycle ROM write strobe.
- `rom_addr` output, ADDR_WIDTH: ROM word address.
- `rom_wdata` output, 32: instruction word to write.
- `cpu_hold` output, 1: holds the CPU in reset while high. The board ORs this with `reset`.
- `load_done` output, 1: the image is loaded and verified. Sticky.
- `load_error` output, 1: the last frame was aborted. Sticky until the next sync byte is received.

## Operation
- Frame format, all multi-byte fields little-endian:
  - sync byte 0x55;
  - word count N, 16 bits;
  - N×4 data bytes;
  - one checksum byte, equal to the XOR of all data bytes.
- State `IDLE`: all bytes other than 0x55 are ignored. On 0x55, clear the byte counter, word index and XOR accumulator, clear `load_error`, and go to `LEN_L`.
- `LEN_L`: latch the count low byte, then go to `LEN_H`.
- `LEN_H`: latch the count high byte. If N==0 or N>2^ADDR_WIDTH, go to `ERR`; otherwise go to `DATA`.
- `DATA`: shift each byte into the word buffer, LSB byte first, and XOR it into the accumulator.
  - On the 4th byte of a word, register `rom_we`=1, `rom_addr`=word index, and `rom_wdata`=the assembled word. Then increment the word index.
  - When the word index reaches N, go to `CHK`.
- `CHK`: if the received byte equals the accumulator, go to `DONE`; otherwise go to `ERR`.
- `DONE`: `cpu_hold`=0 and `load_done`=1. All further bytes are ignored, including 0x55. Only `reset` can start a reload.
- `ERR`: `load_error`=1 and `cpu_hold`=1. A 0x55 byte restarts at `LEN_L`; any other byte is ignored. ROM words written before the abort stay in place, but the CPU is not released.
- Timeout: in `LEN_L`, `LEN_H`, `DATA` and `CHK`, an idle counter counts cycles without `rx_valid`. It is cleared on each `rx_valid`. When it reaches TIMEOUT, go to `ERR`.
- Width rules:
  - The word index is ADDR_WIDTH+1 bits, so that N=2^ADDR_WIDTH is reached without wrap.
  - `rom_addr` is the low ADDR_WIDTH bits of the word index.
  - No write ever targets an address ≥ N.

## Timing
- Reset values: `rom_we`=0, `rom_addr`=0, `rom_wdata`=0, `cpu_hold`=1, `load_done`=0, `load_error`=0. State resets to `IDLE` and all counters to 0.
- `rom_we` goes high in the cycle after the `rx_valid` of each word's 4th byte, for exactly 1 cycle. `rom_addr` and `rom_wdata` are stable in that cycle and hold their values afterwards.
- `cpu_hold` falls, and `load_done` rises, in the cycle after the `rx_valid` of a correct checksum byte.
- On an error, `load_error` rises in the cycle after the offending byte, or in the cycle after the timeout count reaches TIMEOUT.
- Back-to-back `rx_valid`, one byte on every cycle, is accepted without loss. A `rom_we` pulse may overlap acceptance of the next byte.
- If `reset` is asserted mid-frame, outputs return to their reset values immediately. Partial ROM contents are don't-care.

## Test plan
- **Good load.** Send 55 03 00 | 00 02 30 00 | 00 23 10 00 | 0A 00 00 00 | 0B.
  - Expect three `rom_we` pulses: addr0=0x00300200, addr1=0x00102300, addr2=0x0000000A.
  - Then `cpu_hold`=0 and `load_done`=1.
  - After 3 instruction periods, `cpu.gr_file.x[3]`=4.
- **Bad checksum.** Send the same frame with the final byte 0x0C.
  - Expect the three writes, then `load_error`=1, `cpu_hold`=1 and `load_done`=0.
  - Resending the correct frame afterwards must give `load_done`=1.
- **Invalid length.** Send 55 00 00.
  - Expect `load_error`=1 with no `rom_we`.
  - With ADDR_WIDTH=2, 55 05 00 must also give `load_error`=1.
- **Timeout.** With TIMEOUT=16, send 55 01 00 00 02, then idle.
  - Expect `load_error`=1 exactly 16 cycles after the last `rx_valid`, with no `rom_we`.
- **Noise and reset.**
  - Bytes 00 FF AA before the sync are ignored, and the load succeeds.
  - Asserting `reset` mid-`DATA` returns `cpu_hold`=1 and state `IDLE`; the next full frame loads correctly.
  - A 0x55 sent after `DONE` causes no writes and no state change.

Source files
------------

// File: rtl/rom_uart_loader.sv
// rom_uart_loader: frames UART bytes into 32-bit words and writes them to the
// instruction ROM. The CPU stays held until a checksum-valid image is loaded.
// Ports: clk, reset (async, active high); rx_valid/rx_data byte input;
// rom_we/rom_addr/rom_wdata ROM write port; cpu_hold, load_done, load_error.
module rom_uart_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int TIMEOUT    = 100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rom_we,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic [31:0]           rom_wdata,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error
);

  // idle only needs to count up to TIMEOUT-1: the step to TIMEOUT is the
  // edge that enters ERR.
  localparam int IW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [IW-1:0] TLIM = IW'(TIMEOUT - 1);
  localparam logic [16:0] MAX_N = 17'(2 ** ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] WONE = 1;

  typedef enum logic [2:0] {
    IDLE, LEN_L, LEN_H, DATA, CHK, DONE, ERR
  } state_t;

  state_t state, state_n;

  logic [15:0]         len;
  logic [ADDR_WIDTH:0] widx;
  logic [ADDR_WIDTH:0] widx_inc;
  logic [1:0]          bcnt;
  logic [23:0]         wbuf;
  logic [7:0]          xacc;
  logic [IW-1:0]       idle;

  logic        sync;
  logic        timed;
  logic        last_word;
  logic        len_bad;
  logic [15:0] len_n;

  assign sync      = rx_valid && (rx_data == 8'h55);
  assign timed     = (state == LEN_L) || (state == LEN_H) ||
                     (state == DATA)  || (state == CHK);
  assign widx_inc  = widx + WONE;
  assign last_word = (17'(widx_inc) == {1'b0, len});
  assign len_n     = {rx_data, len[7:0]};
  assign len_bad   = (len_n == 16'd0) || ({1'b0, len_n} > MAX_N);
  assign cpu_hold  = ~load_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (sync) state_n = LEN_L;
      LEN_L:   if (rx_valid) state_n = LEN_H;
      LEN_H:   if (rx_valid) state_n = len_bad ? ERR : DATA;
      DATA:    if (rx_valid && bcnt == 2'd3 && last_word) state_n = CHK;
      CHK:     if (rx_valid) state_n = (rx_data == xacc) ? DONE : ERR;
      DONE:    state_n = DONE;
      ERR:     if (sync) state_n = LEN_L;
      default: state_n = IDLE;
    endcase
    if (timed && !rx_valid && idle == TLIM) state_n = ERR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len        <= '0;
      widx       <= '0;
      bcnt       <= '0;
      wbuf       <= '0;
      xacc       <= '0;
      idle       <= '0;
      rom_we     <= 1'b0;
      rom_addr   <= '0;
      rom_wdata  <= '0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      rom_we <= 1'b0;

      if (!timed || rx_valid) idle <= '0;
      else                    idle <= idle + IW'(1);

      unique case (state)
        IDLE, ERR: begin
          if (sync) begin
            bcnt       <= '0;
            widx       <= '0;
            xacc       <= '0;
            load_error <= 1'b0;
          end
        end
        LEN_L: if (rx_valid) len[7:0]  <= rx_data;
        LEN_H: if (rx_valid) len[15:8] <= rx_data;
        DATA: begin
          if (rx_valid) begin
            xacc <= xacc ^ rx_data;
            bcnt <= bcnt + 2'd1;
            // Bytes arrive LSB first, so the buffer shifts right and the
            // 4th byte lands on top of the assembled word.
            wbuf <= {rx_data, wbuf[23:8]};
            if (bcnt == 2'd3) begin
              rom_we    <= 1'b1;
              rom_addr  <= widx[ADDR_WIDTH-1:0];
              rom_wdata <= {rx_data, wbuf};
              widx      <= widx_inc;
            end
          end
        end
        default: ;
      endcase

      if (state_n == ERR && state != ERR) load_error <= 1'b1;
      if (state_n == DONE) load_done <= 1'b1;
    end
  end

endmodule
